// File: rtl/muldiv_ctrl_if.sv
// Bundle between the EX stage and the mult/div controller, including the
// multiplier and divider ports the controller drives.
interface muldiv_ctrl_if;
  // EX side
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        flush;
  logic        ex_hold;
  logic        stallreq;
  logic        hilo_we;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy;
  // multiplier port
  logic        mul_signed;
  logic [31:0] mul_ina;
  logic [31:0] mul_inb;
  logic [63:0] mul_result;
  // divider port
  logic        div_start;
  logic        div_signed;
  logic        div_annul;
  logic [31:0] div_op1;
  logic [31:0] div_op2;
  logic        div_ready;
  logic [63:0] div_result;

  modport master (
    output op_valid, op_code, src1, src2, flush, ex_hold,
    output mul_result, div_ready, div_result,
    input  stallreq, hilo_we, hi_o, lo_o, busy,
    input  mul_signed, mul_ina, mul_inb,
    input  div_start, div_signed, div_annul, div_op1, div_op2
  );

  modport slave (
    input  op_valid, op_code, src1, src2, flush, ex_hold,
    input  mul_result, div_ready, div_result,
    output stallreq, hilo_we, hi_o, lo_o, busy,
    output mul_signed, mul_ina, mul_inb,
    output div_start, div_signed, div_annul, div_op1, div_op2
  );
endinterface

// File: rtl/muldiv_ctrl.sv
// Sequencer for MIPS mult/multu/div/divu: steers operands to an external
// multiplier/divider, stalls EX while they work, and presents the hi/lo result.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic         clk,
  input  logic         resetn,
  muldiv_ctrl_if.slave bus,
  output logic [1:0]   state_dbg
);

  // Handshake: an op is taken in IDLE when op_valid=1 and flush=0; EX must
  // hold the instruction while stallreq=1; the result is committed to hi/lo in
  // exactly the cycle hilo_we=1, and flush cancels everything in that cycle.

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_RUN  = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(MUL_LAT - 1);

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q, hi_n, lo_n;
  logic        load_ops;
  logic        accept;

  assign accept    = (state == IDLE) && bus.op_valid && !bus.flush;
  assign state_dbg = state;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    hi_n     = hi_q;
    lo_n     = lo_q;
    load_ops = 1'b0;
    if (bus.flush) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            load_ops = 1'b1;
            cnt_n    = CNT_INIT;
            if (!bus.op_code[1]) begin
              if (MUL_LAT == 1) begin
                state_n = DONE;
                hi_n    = bus.mul_result[63:32];
                lo_n    = bus.mul_result[31:0];
              end else begin
                state_n = MUL_WAIT;
              end
            end else if (bus.src2 == 32'd0) begin
              // divide by zero never reaches the divider
              state_n = DONE;
              hi_n    = bus.src1;
              lo_n    = 32'd0;
            end else begin
              state_n = DIV_RUN;
            end
          end
        end
        MUL_WAIT: begin
          if (cnt == 3'd0) begin
            state_n = DONE;
            hi_n    = bus.mul_result[63:32];
            lo_n    = bus.mul_result[31:0];
          end else begin
            cnt_n = cnt - 3'd1;
          end
        end
        DIV_RUN: begin
          if (bus.div_ready) begin
            state_n = DONE;
            hi_n    = bus.div_result[63:32];
            lo_n    = bus.div_result[31:0];
          end
        end
        DONE: begin
          if (!bus.ex_hold) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= 3'd0;
      op_q  <= 2'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      hi_q  <= 32'd0;
      lo_q  <= 32'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      if (load_ops) begin
        op_q <= bus.op_code;
        a_q  <= bus.src1;
        b_q  <= bus.src2;
      end
    end
  end

  always_comb begin
    bus.stallreq   = 1'b0;
    bus.hilo_we    = 1'b0;
    bus.hi_o       = 32'd0;
    bus.lo_o       = 32'd0;
    bus.busy       = (state != IDLE);
    bus.mul_signed = 1'b0;
    bus.mul_ina    = 32'd0;
    bus.mul_inb    = 32'd0;
    bus.div_start  = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_annul  = 1'b0;
    bus.div_op1    = 32'd0;
    bus.div_op2    = 32'd0;

    if (!bus.flush) begin
      bus.stallreq = accept || (state == MUL_WAIT) || (state == DIV_RUN);
    end

    // the multiplier sees operands from the accepting cycle on, so its
    // pipeline is already filling before the latched copies take over
    if (accept) begin
      bus.mul_ina    = bus.src1;
      bus.mul_inb    = bus.src2;
      bus.mul_signed = (bus.op_code == 2'b00);
    end else if (state == MUL_WAIT) begin
      bus.mul_ina    = a_q;
      bus.mul_inb    = b_q;
      bus.mul_signed = (op_q == 2'b00);
    end

    if (state == DIV_RUN) begin
      bus.div_op1    = a_q;
      bus.div_op2    = b_q;
      bus.div_signed = (op_q == 2'b10);
      bus.div_start  = !bus.div_ready && !bus.flush;
      bus.div_annul  = bus.flush;
    end

    if (state == DONE) begin
      bus.hi_o    = hi_q;
      bus.lo_o    = lo_q;
      bus.hilo_we = !bus.ex_hold && !bus.flush;
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: table of ops with hand-computed hi/lo plus
// hand-written flush, ex_hold, reset and stray-ready sequences.
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 2;

  logic clk;
  logic resetn;
  logic [1:0] state_dbg;

  muldiv_ctrl_if bus ();

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- multiplier model ----------------
  logic [63:0] prod;
  logic [63:0] mpipe [MUL_LAT];

  always_comb begin
    if (bus.mul_signed)
      prod = 64'($signed({{32{bus.mul_ina[31]}}, bus.mul_ina}) *
                 $signed({{32{bus.mul_inb[31]}}, bus.mul_inb}));
    else
      prod = {32'd0, bus.mul_ina} * {32'd0, bus.mul_inb};
  end

  always @(posedge clk) begin
    mpipe[0] <= prod;
    for (int i = 1; i < MUL_LAT; i++) mpipe[i] <= mpipe[i-1];
  end
  assign bus.mul_result = mpipe[MUL_LAT-1];

  // ---------------- divider model ----------------
  int   div_lat;
  int   dcnt;
  logic drun;
  logic ready_kick;
  logic [31:0] dq, dr;

  always @(posedge clk) begin
    if (!resetn || bus.div_annul) begin
      drun <= 1'b0;
      dcnt <= 0;
    end else if (drun && bus.div_ready) begin
      drun <= 1'b0;
      dcnt <= 0;
    end else if (drun) begin
      dcnt <= dcnt + 1;
    end else if (bus.div_start) begin
      drun <= 1'b1;
      dcnt <= 1;
    end
  end

  always_comb begin
    dq = 32'd0;
    dr = 32'd0;
    if (bus.div_op2 != 32'd0) begin
      if (bus.div_signed) begin
        dq = $signed(bus.div_op1) / $signed(bus.div_op2);
        dr = $signed(bus.div_op1) % $signed(bus.div_op2);
      end else begin
        dq = bus.div_op1 / bus.div_op2;
        dr = bus.div_op1 % bus.div_op2;
      end
    end
  end

  assign bus.div_ready  = (drun && (dcnt == div_lat - 1)) || ready_kick;
  assign bus.div_result = {dr, dq};

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int we_cnt  = 0;

  always @(negedge clk) if (bus.hilo_we) we_cnt++;

  logic [198:0] all_out;
  assign all_out = {bus.stallreq, bus.hilo_we, bus.div_start, bus.div_annul, bus.busy,
                    bus.mul_signed, bus.div_signed, bus.hi_o, bus.lo_o,
                    bus.mul_ina, bus.mul_inb, bus.div_op1, bus.div_op2};

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
    int          starts;
  } vec_t;

  task automatic run_op(input string tag, input vec_t v);
    int   stalls;
    int   starts;
    logic done;
    stalls = 0;
    starts = 0;
    done   = 1'b0;
    step();
    bus.op_valid = 1'b1;
    bus.op_code  = v.op;
    bus.src1     = v.a;
    bus.src2     = v.b;
    bus.ex_hold  = 1'b0;
    div_lat      = v.lat;
    @(negedge clk);
    check({tag, " accept_stall"}, 256'(bus.stallreq), 256'(1));
    if (!v.op[1])
      check({tag, " mul_operands"}, {bus.mul_signed, bus.mul_ina, bus.mul_inb},
            {(v.op == 2'b00), v.a, v.b});
    step();
    bus.op_valid = 1'b0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      if (bus.hilo_we) done = 1'b1;
      else begin
        if (bus.stallreq)  stalls++;
        if (bus.div_start) starts++;
        step();
      end
    end
    check({tag, " done_seen"}, 256'(done), 256'(1));
    check({tag, " hi_lo"}, {bus.hi_o, bus.lo_o}, {v.hi, v.lo});
    check({tag, " done_no_stall"}, 256'(bus.stallreq), 256'(0));
    check({tag, " stall_cycles"}, 256'(stalls), 256'(v.stalls));
    check({tag, " div_start_cycles"}, 256'(starts), 256'(v.starts));
    step();
    @(negedge clk);
    check({tag, " back_idle"}, {bus.busy, bus.hilo_we}, 256'(0));
  endtask

  // ---------------- test ----------------
  vec_t vecs[12];
  vec_t v;
  int   we0;
  int   hold_bad;
  logic found;

  initial begin
    vecs[0]  = '{2'b00, 32'hFFFFFFFD, 32'h00000004, 0,  32'hFFFFFFFF, 32'hFFFFFFF4, 2,  0};
    vecs[1]  = '{2'b01, 32'h00000002, 32'h00000003, 0,  32'h00000000, 32'h00000006, 2,  0};
    vecs[2]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,  32'hFFFFFFFE, 32'h00000001, 2,  0};
    vecs[3]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0,  32'h00000000, 32'h00000001, 2,  0};
    vecs[4]  = '{2'b00, 32'h80000000, 32'h80000000, 0,  32'h40000000, 32'h00000000, 2,  0};
    vecs[5]  = '{2'b01, 32'h00010000, 32'h00010000, 0,  32'h00000001, 32'h00000000, 2,  0};
    vecs[6]  = '{2'b11, 32'd100,      32'd7,        33, 32'd2,        32'd14,       33, 32};
    vecs[7]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 5,  32'hFFFFFFFF, 32'hFFFFFFFD, 5,  4};
    vecs[8]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 3,  32'h00000001, 32'h7FFFFFFC, 3,  2};
    vecs[9]  = '{2'b10, 32'd5,        32'd0,        0,  32'd5,        32'd0,        0,  0};
    vecs[10] = '{2'b11, 32'hDEADBEEF, 32'd0,        0,  32'hDEADBEEF, 32'd0,        0,  0};
    vecs[11] = '{2'b10, 32'd7,        32'hFFFFFFFE, 2,  32'h00000001, 32'hFFFFFFFD, 2,  1};

    resetn       = 1'b0;
    bus.op_valid = 1'b0;
    bus.op_code  = 2'b00;
    bus.src1     = 32'd0;
    bus.src2     = 32'd0;
    bus.flush    = 1'b0;
    bus.ex_hold  = 1'b0;
    ready_kick   = 1'b0;
    div_lat      = 2;

    // reset state
    step();
    step();
    @(negedge clk);
    check("reset_outputs", 256'(all_out), 256'(0));
    step();
    resetn = 1'b1;
    @(negedge clk);
    check("after_reset_outputs", 256'(all_out), 256'(0));

    // table-driven ops
    for (int i = 0; i < 12; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // flush on the 10th DIV_RUN cycle, then a multu must still work
    we0 = we_cnt;
    step();
    bus.op_valid = 1'b1;
    bus.op_code  = 2'b11;
    bus.src1     = 32'd100;
    bus.src2     = 32'd7;
    div_lat      = 33;
    step();
    bus.op_valid = 1'b0;
    for (int i = 1; i < 10; i++) step();
    bus.flush = 1'b1;
    @(negedge clk);
    check("flush_cycle", {bus.div_annul, bus.stallreq, bus.hilo_we}, 256'(3'b100));
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    check("after_flush", {bus.div_annul, bus.busy, bus.stallreq}, 256'(0));
    check("flush_no_hilo_we", 256'(we_cnt), 256'(we0));
    v = '{2'b01, 32'd2, 32'd3, 0, 32'd0, 32'd6, 2, 0};
    run_op("post_flush_multu", v);

    // DONE held by ex_hold for 3 cycles while op_valid stays high
    step();
    bus.op_valid = 1'b1;
    bus.op_code  = 2'b01;
    bus.src1     = 32'd3;
    bus.src2     = 32'd5;
    bus.ex_hold  = 1'b1;
    found = 1'b0;
    for (int cyc = 0; cyc < 20 && !found; cyc++) begin
      @(negedge clk);
      if (bus.busy && !bus.stallreq) found = 1'b1;
      else step();
    end
    check("hold_reach_done", 256'(found), 256'(1));
    hold_bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) begin
        step();
        @(negedge clk);
      end
      if (bus.hilo_we || bus.stallreq || !bus.busy) hold_bad++;
    end
    check("hold_no_we_no_accept", 256'(hold_bad), 256'(0));
    check("hold_values", {bus.hi_o, bus.lo_o}, {32'd0, 32'd15});
    step();
    bus.ex_hold = 1'b0;
    @(negedge clk);
    check("hold_release_we", {bus.hilo_we, bus.hi_o, bus.lo_o}, {1'b1, 32'd0, 32'd15});
    step();
    @(negedge clk);
    check("accept_after_done", {bus.busy, bus.stallreq}, 256'(2'b01));
    step();
    bus.op_valid = 1'b0;
    bus.flush    = 1'b1;
    step();
    bus.flush = 1'b0;
    @(negedge clk);
    check("hold_cleanup_idle", 256'(bus.busy), 256'(0));

    // flush in IDLE overrides op_valid
    step();
    bus.op_valid = 1'b1;
    bus.op_code  = 2'b00;
    bus.flush    = 1'b1;
    @(negedge clk);
    check("idle_flush_no_stall", 256'(bus.stallreq), 256'(0));
    step();
    bus.op_valid = 1'b0;
    bus.flush    = 1'b0;
    @(negedge clk);
    check("idle_flush_not_taken", 256'(bus.busy), 256'(0));

    // stray div_ready in IDLE is ignored
    step();
    ready_kick = 1'b1;
    step();
    ready_kick = 1'b0;
    @(negedge clk);
    check("stray_ready_ignored", {bus.busy, bus.hilo_we}, 256'(0));

    // reset in the middle of a divide
    we0 = we_cnt;
    step();
    bus.op_valid = 1'b1;
    bus.op_code  = 2'b10;
    bus.src1     = 32'd100;
    bus.src2     = 32'd7;
    div_lat      = 33;
    step();
    bus.op_valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    resetn = 1'b0;
    @(negedge clk);
    check("reset_cycle_no_annul", {bus.div_annul, bus.div_start}, 256'(2'b01));
    step();
    @(negedge clk);
    check("reset_mid_div_outputs", 256'(all_out), 256'(0));
    step();
    resetn = 1'b1;
    @(negedge clk);
    check("reset_mid_div_idle", 256'(all_out), 256'(0));
    check("reset_no_hilo_we", 256'(we_cnt), 256'(we0));

    // normal op after the reset
    run_op("post_reset", vecs[1]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
